// File: rtl/ternary_conv5x5.sv
// ternary_conv5x5
//   Streaming 5x5 convolution with ternary weights over a raster-order
//   IMG_W x IMG_H unsigned 8-bit image. It emits the (IMG_H-4)x(IMG_W-4)
//   valid-region feature map in raster order: bias add, ReLU, arithmetic
//   right shift by SHIFT, then saturation to 8 bits.
//
// Ports
//   clk     : clock, all state on the rising edge
//   resetn  : asynchronous reset, active high (asserted = 1)
//   i_d     : input pixel, unsigned 8 bit
//   i_v     : input pixel valid, one pixel per cycle, no backpressure
//   w       : 25 ternary weights, w[2*(5*r+c)+:2] for row r, col c
//             (0 = oldest); 01 = +1, 11 = -1, 00/10 = 0
//   bias    : signed 16-bit bias (w and bias are held stable per frame)
//   o_d     : output feature pixel, holds its value while o_v = 0
//   o_v     : output valid, one pulse per qualifying input pixel
//   o_last  : marks the final output pixel of a frame
module ternary_conv5x5 #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int SHIFT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  i_d,
  input  logic        i_v,
  input  logic [49:0] w,
  input  logic [15:0] bias,
  output logic [7:0]  o_d,
  output logic        o_v,
  output logic        o_last
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          col_end, row_end, qual, frame_end;

  logic          v0_q, v1_q, l0_q, l1_q;
  logic          o_v_q, o_last_q;
  logic [7:0]    o_d_q;

  logic [7:0]         lb_q [4][IMG_W];
  logic [4:0][7:0]    newcol;
  logic [4:0][4:0][7:0] win_q;   // [row][col], index 0 is oldest

  logic signed [11:0] psum_d [5];
  logic signed [11:0] psum_q [5];
  logic signed [17:0] acc;
  logic [17:0]        q;
  logic [7:0]         res_d;

  assign col_end   = (col_q == CW'(IMG_W - 1));
  assign row_end   = (row_q == RW'(IMG_H - 1));
  // A full 5x5 window exists only once 4 rows and 4 columns precede the pixel,
  // so windows never straddle a row or frame wrap.
  assign qual      = i_v && (row_q >= RW'(4)) && (col_q >= CW'(4));
  assign frame_end = qual && row_end && col_end;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (i_v) begin
      if (col_end) begin
        col_d = '0;
        row_d = row_end ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // New window column: oldest buffered row at index 0, live pixel at index 4.
  always_comb begin
    newcol[0] = lb_q[3][col_q];
    newcol[1] = lb_q[2][col_q];
    newcol[2] = lb_q[1][col_q];
    newcol[3] = lb_q[0][col_q];
    newcol[4] = i_d;
  end

  // Line buffers cascade at the current column: each one takes the row held
  // by the buffer above it, so lb_q[k] always holds row (current - 1 - k).
  always_ff @(posedge clk) begin
    if (i_v) begin
      lb_q[0][col_q] <= i_d;
      for (int k = 1; k < 4; k++) lb_q[k][col_q] <= lb_q[k-1][col_q];
      for (int r = 0; r < 5; r++) begin
        for (int c = 0; c < 4; c++) win_q[r][c] <= win_q[r][c+1];
        win_q[r][4] <= newcol[r];
      end
    end
  end

  // 12 bits per row sum: five pixels of up to 255 reach +/-1275.
  always_comb begin
    for (int r = 0; r < 5; r++) begin
      psum_d[r] = '0;
      for (int c = 0; c < 5; c++) begin
        case (w[2*(5*r+c) +: 2])
          2'b01:   psum_d[r] = psum_d[r] + $signed({4'b0, win_q[r][c]});
          2'b11:   psum_d[r] = psum_d[r] - $signed({4'b0, win_q[r][c]});
          default: psum_d[r] = psum_d[r];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (v0_q) begin
      for (int r = 0; r < 5; r++) psum_q[r] <= psum_d[r];
    end
  end

  always_comb begin
    acc = $signed({{2{bias[15]}}, bias});
    for (int r = 0; r < 5; r++) acc = acc + $signed({{6{psum_q[r][11]}}, psum_q[r]});
    q = acc >>> SHIFT;
    if (acc[17])        res_d = 8'h00;
    else if (|q[17:8])  res_d = 8'hFF;
    else                res_d = q[7:0];
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      col_q    <= '0;
      row_q    <= '0;
      v0_q     <= 1'b0;
      l0_q     <= 1'b0;
      v1_q     <= 1'b0;
      l1_q     <= 1'b0;
      o_v_q    <= 1'b0;
      o_last_q <= 1'b0;
      o_d_q    <= 8'h00;
    end else begin
      col_q    <= col_d;
      row_q    <= row_d;
      v0_q     <= qual;
      l0_q     <= frame_end;
      v1_q     <= v0_q;
      l1_q     <= l0_q;
      o_v_q    <= v1_q;
      o_last_q <= l1_q;
      if (v1_q) o_d_q <= res_d;
    end
  end

  assign o_d    = o_d_q;
  assign o_v    = o_v_q;
  assign o_last = o_last_q;

endmodule
